// File: rtl/bisection_pkg.sv
// Shared types and sizing helpers for the bisection tracker.
// State encoding, plant polarity codes and counter width functions.
package bisection_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam bit POL_DIRECT  = 1'b0;
    localparam bit POL_INVERSE = 1'b1;

    function automatic int iter_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

    function automatic int timeout_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/bisection_abs_err.sv
// Combinational |x - y| over unsigned operands.
// The result is one bit wider and signed, so it can never overflow.
module bisection_abs_err #(
    parameter int W = 10
) (
    input  logic [W-1:0]      x,
    input  logic [W-1:0]      y,
    output logic signed [W:0] abs_diff
);

    logic signed [W:0] diff_s;

    // Widen both operands with a zero MSB, subtract, then fold the sign.
    always_comb begin
        diff_s = $signed({1'b0, x}) - $signed({1'b0, y});
        if (diff_s[W]) begin
            abs_diff = -diff_s;
        end else begin
            abs_diff = diff_s;
        end
    end

endmodule

// File: rtl/bisection_tracker.sv
// Bisection search of i_ref until the measured Q is within TOL of the target,
// with iteration cap, measurement timeout and optional drift re-tracking.
module bisection_tracker
    import bisection_pkg::*;
#(
    parameter int BUS_WIDTH   = 10,
    parameter int TOL         = 1,
    parameter int RETRACK_TOL = 4,
    parameter int MAX_ITER    = 16,
    parameter int TIMEOUT     = 1023,
    parameter bit POLARITY    = POL_DIRECT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            start,
    input  logic                            track,
    input  logic [BUS_WIDTH-1:0]            lo_bound,
    input  logic [BUS_WIDTH-1:0]            hi_bound,
    input  logic [BUS_WIDTH-1:0]            q_desired,
    input  logic [BUS_WIDTH-1:0]            q_measured,
    input  logic                            meas_ready,
    output logic                            meas_req,
    output logic [BUS_WIDTH-1:0]            i_ref,
    output logic                            busy,
    output logic                            converged,
    output logic                            failed,
    output logic                            timed_out,
    output logic [iter_width(MAX_ITER)-1:0] iter_count
);

    localparam int W  = BUS_WIDTH;
    localparam int WP = BUS_WIDTH + 1;
    localparam int IW = iter_width(MAX_ITER);
    localparam int TW = timeout_width(TIMEOUT);
    localparam logic signed [W:0] TOL_S     = WP'(TOL);
    localparam logic signed [W:0] RETRACK_S = WP'(RETRACK_TOL);
    localparam logic [IW-1:0]     ITER_CAP  = IW'(MAX_ITER);
    localparam logic [TW-1:0]     TMO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [W-1:0]      ONE_W     = W'(1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   lo_l_q, lo_l_d, hi_l_q, hi_l_d;
    logic [W-1:0]   q_lat_q, q_lat_d;
    logic [W-1:0]   i_ref_q, i_ref_d;
    logic           track_q, track_d;
    logic           meas_req_q, meas_req_d;
    logic           busy_q, busy_d;
    logic           conv_q, conv_d, fail_q, fail_d, to_q, to_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           tmo_hit_s;
    logic [W-1:0]   mid_s;
    logic [W-1:0]   err_src_s;
    logic signed [W:0] err_s;
    logic           raise_s;

    // In DONE the live measurement is checked for drift; otherwise the latched sample.
    assign err_src_s = (state_q == ST_DONE) ? q_measured : q_lat_q;
    assign mid_s     = W'(({1'b0, a_q} + {1'b0, b_q}) >> 1);
    assign raise_s   = (q_desired > q_lat_q) ^ POLARITY;

    bisection_abs_err #(.W(W)) u_abs_err (
        .x        (err_src_s),
        .y        (q_desired),
        .abs_diff (err_s)
    );

    // WAIT-state cycle counter; restarts whenever the FSM is elsewhere.
    always_comb begin
        tmo_d     = '0;
        tmo_hit_s = 1'b0;
        if (state_q == ST_WAIT) begin
            tmo_d     = tmo_q + TW'(1);
            tmo_hit_s = (TIMEOUT > 0) && (tmo_q == TMO_LAST);
        end else begin
            tmo_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Search FSM: next state, bounds, drive code and sticky flags.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        lo_l_d     = lo_l_q;
        hi_l_d     = hi_l_q;
        track_d    = track_q;
        q_lat_d    = q_lat_q;
        i_ref_d    = i_ref_q;
        meas_req_d = 1'b0;
        conv_d     = conv_q;
        fail_d     = fail_q;
        to_d       = to_q;
        iter_d     = iter_q;
        if (!enable) begin
            state_d = ST_IDLE;
            conv_d  = 1'b0;
            fail_d  = 1'b0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_SETUP;
                        lo_l_d  = lo_bound;
                        hi_l_d  = hi_bound;
                        track_d = track;
                        conv_d  = 1'b0;
                        fail_d  = 1'b0;
                        to_d    = 1'b0;
                        iter_d  = '0;
                    end else if ((state_q == ST_DONE) && track_q && meas_ready && (err_s > RETRACK_S)) begin
                        // Drift relaunch is a fresh search over the originally latched window.
                        state_d = ST_SETUP;
                        conv_d  = 1'b0;
                        fail_d  = 1'b0;
                        to_d    = 1'b0;
                        iter_d  = '0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SETUP: begin
                    a_d = lo_l_q;
                    b_d = hi_l_q;
                    if (lo_l_q > hi_l_q) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    i_ref_d    = mid_s;
                    meas_req_d = 1'b1;
                    iter_d     = iter_q + IW'(1);
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready coincident with the request belongs to an older measurement.
                    if (meas_ready && !meas_req_q) begin
                        q_lat_d = q_measured;
                        state_d = ST_EVAL;
                    end else if (tmo_hit_s) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                        to_d    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_EVAL: begin
                    if (err_s <= TOL_S) begin
                        state_d = ST_DONE;
                        conv_d  = 1'b1;
                    end else if ((iter_q == ITER_CAP) || ((b_q - a_q) <= ONE_W)) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end else begin
                        if (raise_s) begin
                            a_d = i_ref_q;
                        end else begin
                            b_d = i_ref_q;
                        end
                        state_d = ST_DRIVE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_SETUP) || (state_d == ST_DRIVE) ||
                 (state_d == ST_WAIT)  || (state_d == ST_EVAL);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            lo_l_q     <= '0;
            hi_l_q     <= '0;
            track_q    <= 1'b0;
            q_lat_q    <= '0;
            i_ref_q    <= '0;
            meas_req_q <= 1'b0;
            busy_q     <= 1'b0;
            conv_q     <= 1'b0;
            fail_q     <= 1'b0;
            to_q       <= 1'b0;
            iter_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            lo_l_q     <= lo_l_d;
            hi_l_q     <= hi_l_d;
            track_q    <= track_d;
            q_lat_q    <= q_lat_d;
            i_ref_q    <= i_ref_d;
            meas_req_q <= meas_req_d;
            busy_q     <= busy_d;
            conv_q     <= conv_d;
            fail_q     <= fail_d;
            to_q       <= to_d;
            iter_q     <= iter_d;
        end
    end

    assign meas_req   = meas_req_q;
    assign i_ref      = i_ref_q;
    assign busy       = busy_q;
    assign converged  = conv_q;
    assign failed     = fail_q;
    assign timed_out  = to_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_bisection_tracker.sv
// Directed bench for bisection_tracker: two instances (direct and inverted plant)
// with a simple 3-cycle-latency plant model and hand-computed expectations.
module tb_bisection_tracker;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, track;
    logic start0, start1;
    logic [W-1:0] lo, hi, qd;

    logic [W-1:0] q0, iref0, q1, iref1;
    logic rdy0, req0, busy0, conv0, fail0, to0;
    logic rdy1, req1, busy1, conv1, fail1, to1;
    logic [4:0] iter0, iter1;

    int  offset   = 0;
    bit  quarter  = 1'b0;
    bit  plant_on = 1'b1;
    bit  man0     = 1'b0;
    int  cnt0     = 0;
    int  cnt1     = 0;
    int  seq0[$];

    int n_checks = 0;
    int n_pass   = 0;

    bisection_tracker #(.TIMEOUT(20)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .start(start0), .track(track),
        .lo_bound(lo), .hi_bound(hi), .q_desired(qd), .q_measured(q0),
        .meas_ready(rdy0), .meas_req(req0), .i_ref(iref0), .busy(busy0),
        .converged(conv0), .failed(fail0), .timed_out(to0), .iter_count(iter0)
    );

    bisection_tracker #(.TIMEOUT(20), .POLARITY(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start1), .track(track),
        .lo_bound(lo), .hi_bound(hi), .q_desired(qd), .q_measured(q1),
        .meas_ready(rdy1), .meas_req(req1), .i_ref(iref1), .busy(busy1),
        .converged(conv1), .failed(fail1), .timed_out(to1), .iter_count(iter1)
    );

    // Plant models: ready pulses 3 cycles after each request.
    assign q0   = quarter ? {2'b00, iref0[9:2]} : 10'(iref0 + 10'(offset));
    assign rdy0 = (cnt0 == 1) || man0;
    assign q1   = 10'd1023 - iref1;
    assign rdy1 = (cnt1 == 1);

    always @(posedge clk) begin
        if (req0 && plant_on) cnt0 <= 3;
        else if (cnt0 != 0)   cnt0 <= cnt0 - 1;
        if (req1)             cnt1 <= 3;
        else if (cnt1 != 0)   cnt1 <= cnt1 - 1;
        if (req0)             seq0.push_back(int'(iref0));
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit which, input string tag);
        int n = 0;
        while ((which ? busy1 : busy0) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, int'(which ? busy1 : busy0), 0);
    endtask

    int exp1[8] = '{511, 255, 383, 319, 287, 303, 295, 299};

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; track = 1'b0; start0 = 1'b0; start1 = 1'b0;
        lo = 10'd0; hi = 10'd1023; qd = 10'd300;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_iref", iref0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_flags", {conv0, fail0, to0, req0}, 0);
        chk("rst_iter", iter0, 0);

        // Direct plant, full window, target 300
        seq0.delete();
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t1_setup_busy", busy0, 1);
        tick();
        chk("t1_drive_noreq", req0, 0);
        tick();
        chk("t1_req_latency", req0, 1);
        chk("t1_first_iref", iref0, 511);
        wait_idle(1'b0, "t1_finish");
        chk("t1_nreq", seq0.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t1_iref%0d", i), (i < seq0.size()) ? seq0[i] : -1, exp1[i]);
        chk("t1_conv", conv0, 1);
        chk("t1_fail", fail0, 0);
        chk("t1_iter", iter0, 8);

        // Inverted plant q = 1023 - i_ref, target 723
        qd = 10'd723;
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_idle(1'b1, "t2_finish");
        chk("t2_conv", conv1, 1);
        chk("t2_iref", iref1, 299);
        chk("t2_iter", iter1, 8);
        chk("t2_fail", fail1, 0);

        // Unreachable target: window exhaustion
        quarter = 1'b1; qd = 10'd1000;
        start0 = 1'b1; tick(); start0 = 1'b0;
        wait_idle(1'b0, "t3_finish");
        chk("t3_fail", fail0, 1);
        chk("t3_conv", conv0, 0);
        chk("t3_timeout", to0, 0);
        chk("t3_iter", iter0, 11);
        chk("t3_iref", iref0, 1022);

        // No ready at all: timeout 20 cycles after meas_req
        quarter = 1'b0; plant_on = 1'b0; qd = 10'd300;
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (!req0 && n < 10) begin tick(); n++; end
        chk("t4_req_seen", req0, 1);
        n = 0;
        while (!to0 && n < 40) begin tick(); n++; end
        chk("t4_tmo_cycles", n, 20);
        chk("t4_fail", fail0, 1);
        chk("t4_busy", busy0, 0);

        // Abort in WAIT, then inverted bounds
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (!req0 && n < 10) begin tick(); n++; end
        tick();
        enable = 1'b0; tick();
        chk("t5_abort_busy", busy0, 0);
        chk("t5_abort_iref", iref0, 511);
        chk("t5_abort_flags", {conv0, fail0, to0}, 0);
        chk("t5_other_conv_clr", conv1, 0);
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t5_start_vs_abort", busy0, 0);
        enable = 1'b1; lo = 10'd600; hi = 10'd100;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t5_setup_busy", busy0, 1);
        tick();
        chk("t5_bad_fail", fail0, 1);
        chk("t5_bad_busy", busy0, 0);
        chk("t5_bad_iref", iref0, 511);

        // Tracking: converge, tolerate small drift, relaunch on large drift
        plant_on = 1'b1; lo = 10'd0; hi = 10'd1023; track = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0; track = 1'b0;
        n = 0;
        while (!req0 && n < 10) begin tick(); n++; end
        lo = 10'd500; hi = 10'd600;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t6_start_ignored", busy0, 1);
        chk("t6_iter_kept", iter0, 1);
        wait_idle(1'b0, "t6_finish1");
        chk("t6_conv1", conv0, 1);
        chk("t6_iref1", iref0, 299);
        offset = 3;
        man0 = 1'b1; tick(); man0 = 1'b0;
        chk("t6_small_drift_busy", busy0, 0);
        chk("t6_small_drift_conv", conv0, 1);
        offset = 10;
        man0 = 1'b1; tick(); man0 = 1'b0;
        chk("t6_relaunch_busy", busy0, 1);
        chk("t6_relaunch_conv", conv0, 0);
        wait_idle(1'b0, "t6_finish2");
        chk("t6_conv2", conv0, 1);
        chk("t6_iref2", iref0, 291);
        chk("t6_iter2", iter0, 8);

        // Reset in the middle of a search
        offset = 0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t7_rst_busy", busy0, 0);
        chk("t7_rst_iref", iref0, 0);
        chk("t7_rst_conv", conv0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
